// File: rtl/ula_74181_seq.sv
// ula_74181_seq: slice-serial 74181-style ALU on WIDTH-bit operands.
// Operands arrive on a valid/ready handshake. They are processed 4 bits
// per clock, with the carry held in a register between slices. The result
// is presented on a second valid/ready handshake.
// Build option: define ULA_74181_PARALLEL_EN to evaluate every slice in
// a single BUSY cycle, with the carry rippling combinationally across the
// slices.
// WIDTH must be a multiple of 4 and at least 4.
module ula_74181_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             c_out,
   output logic             a_eq_b,
   output logic             zero
);

   localparam int NSLICE = WIDTH / 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Operation latched at acceptance; it stays stable for the whole run.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [3:0]       s_reg;
   logic             m_reg;
   logic             carry_reg;

   logic [WIDTH-1:0] f_reg;
   logic             c_out_reg;
   logic             a_eq_b_reg;
   logic             zero_reg;

   // Full-width bitwise operands of the adder (X, Y) and the logic result.
   logic [WIDTH-1:0] x_op;
   logic [WIDTH-1:0] y_op;
   logic [WIDTH-1:0] logic_res;

   // Result of the current BUSY cycle.
   logic [WIDTH-1:0] f_next;
   logic             carry_next;
   logic             slice_last;

   // Decode the function select into the adder operands and the logic result.
   always_comb begin
      x_op      = a_reg;
      y_op      = '0;
      logic_res = '0;
      case (s_reg)
         4'b0000: begin x_op = a_reg;          y_op = '0;             logic_res = ~a_reg;            end
         4'b0001: begin x_op = a_reg | b_reg;  y_op = '0;             logic_res = ~(a_reg | b_reg);  end
         4'b0010: begin x_op = a_reg | ~b_reg; y_op = '0;             logic_res = ~a_reg & b_reg;    end
         4'b0011: begin x_op = '0;             y_op = '1;             logic_res = '0;                end
         4'b0100: begin x_op = a_reg;          y_op = a_reg & ~b_reg; logic_res = ~(a_reg & b_reg);  end
         4'b0101: begin x_op = a_reg | b_reg;  y_op = a_reg & ~b_reg; logic_res = ~b_reg;            end
         4'b0110: begin x_op = a_reg;          y_op = ~b_reg;         logic_res = a_reg ^ b_reg;     end
         4'b0111: begin x_op = a_reg & ~b_reg; y_op = '1;             logic_res = a_reg & ~b_reg;    end
         4'b1000: begin x_op = a_reg;          y_op = a_reg & b_reg;  logic_res = ~a_reg | b_reg;    end
         4'b1001: begin x_op = a_reg;          y_op = b_reg;          logic_res = ~(a_reg ^ b_reg);  end
         4'b1010: begin x_op = a_reg | ~b_reg; y_op = a_reg & b_reg;  logic_res = b_reg;             end
         4'b1011: begin x_op = a_reg & b_reg;  y_op = '1;             logic_res = a_reg & b_reg;     end
         4'b1100: begin x_op = a_reg;          y_op = a_reg;          logic_res = '1;                end
         4'b1101: begin x_op = a_reg | b_reg;  y_op = a_reg;          logic_res = a_reg | ~b_reg;    end
         4'b1110: begin x_op = a_reg | ~b_reg; y_op = a_reg;          logic_res = a_reg | b_reg;     end
         default: begin x_op = a_reg;          y_op = '1;             logic_res = a_reg;             end
      endcase
   end

`ifdef ULA_74181_PARALLEL_EN
   // All slices in one cycle: carry ripples combinationally through the chain.
   logic [NSLICE:0] carry_chain;

   assign carry_chain[0] = carry_reg;

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      logic [4:0] sum_g;
      assign sum_g = {1'b0, x_op[gi*4 +: 4]} + {1'b0, y_op[gi*4 +: 4]}
                   + {4'b0000, carry_chain[gi]};
      assign carry_chain[gi+1]  = sum_g[4];
      assign f_next[gi*4 +: 4] = m_reg ? logic_res[gi*4 +: 4] : sum_g[3:0];
   end

   assign carry_next = m_reg ? 1'b0 : carry_chain[NSLICE];
   assign slice_last = 1'b1;
`else
   // One slice per cycle, selected by the slice index.
   localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   logic [IDX_W-1:0] idx_reg;
   logic [3:0]       x_sl [NSLICE];
   logic [3:0]       y_sl [NSLICE];
   logic [3:0]       l_sl [NSLICE];
   logic [3:0]       r_slice;
   logic [4:0]       sum_slice;

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign x_sl[gi] = x_op[gi*4 +: 4];
      assign y_sl[gi] = y_op[gi*4 +: 4];
      assign l_sl[gi] = logic_res[gi*4 +: 4];
      // Only the slice being evaluated changes; the others keep their value.
      assign f_next[gi*4 +: 4] = (idx_reg == IDX_W'(gi)) ? r_slice : f_reg[gi*4 +: 4];
   end

   assign sum_slice  = {1'b0, x_sl[idx_reg]} + {1'b0, y_sl[idx_reg]} + {4'b0000, carry_reg};
   assign r_slice    = m_reg ? l_sl[idx_reg] : sum_slice[3:0];
   assign carry_next = m_reg ? 1'b0 : sum_slice[4];
   assign slice_last = (idx_reg == IDX_W'(NSLICE - 1));

   // Slice index: cleared on acceptance, advanced once per BUSY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)
         idx_reg <= '0;
      else if (state_reg == IDLE && in_valid)
         idx_reg <= '0;
      else if (state_reg == BUSY)
         idx_reg <= idx_reg + IDX_W'(1);
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)   state_next = BUSY;
         BUSY:    if (slice_last) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are decoded directly from the state.
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   // Datapath: latch the operation, accumulate slices, and capture final flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         s_reg      <= '0;
         m_reg      <= 1'b0;
         carry_reg  <= 1'b0;
         f_reg      <= '0;
         c_out_reg  <= 1'b0;
         a_eq_b_reg <= 1'b0;
         zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  s_reg      <= s;
                  m_reg      <= m;
                  carry_reg  <= c_in;
                  a_eq_b_reg <= (a == b);
               end
            end
            BUSY: begin
               f_reg     <= f_next;
               carry_reg <= carry_next;
               if (slice_last) begin
                  c_out_reg <= carry_next;
                  zero_reg  <= (f_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign f      = f_reg;
   assign c_out  = c_out_reg;
   assign a_eq_b = a_eq_b_reg;
   assign zero   = zero_reg;

endmodule

// File: tb/tb_ula_74181_seq.sv
// tb_ula_74181_seq: table-driven and scoreboard checks for ula_74181_seq
// at WIDTH=16. It also checks latency, backpressure and reset during BUSY.
module tb_ula_74181_seq;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;
`ifdef ULA_74181_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = NSLICE;
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  s;
      logic        m;
      logic        c;
      logic [15:0] ef;
      logic        eco;
      logic        eeq;
      logic        ez;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             m;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             c_out;
   logic             a_eq_b;
   logic             zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t exp_q[$];
   vec_t tbl[12];

   ula_74181_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .c_out(c_out), .a_eq_b(a_eq_b), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t hv(input logic [15:0] a_v, input logic [15:0] b_v, input logic [3:0] s_v,
                               input logic m_v, input logic c_v, input logic [15:0] ef,
                               input logic eco, input logic eeq, input logic ez);
      vec_t v;
      v.a = a_v; v.b = b_v; v.s = s_v; v.m = m_v; v.c = c_v;
      v.ef = ef; v.eco = eco; v.eeq = eeq; v.ez = ez;
      return v;
   endfunction

   // Full-width reference: X + Y + c_in as a single 17-bit sum.
   function automatic vec_t model(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] sv,
                                  input logic mv, input logic cv);
      logic [15:0] x, y, l;
      logic [16:0] sum;
      vec_t v;
      x = av; y = 16'h0000; l = 16'h0000;
      case (sv)
         4'h0: begin x = av;       y = 16'h0000;  l = ~av;        end
         4'h1: begin x = av | bv;  y = 16'h0000;  l = ~(av | bv); end
         4'h2: begin x = av | ~bv; y = 16'h0000;  l = ~av & bv;   end
         4'h3: begin x = 16'h0000; y = 16'hFFFF;  l = 16'h0000;   end
         4'h4: begin x = av;       y = av & ~bv;  l = ~(av & bv); end
         4'h5: begin x = av | bv;  y = av & ~bv;  l = ~bv;        end
         4'h6: begin x = av;       y = ~bv;       l = av ^ bv;    end
         4'h7: begin x = av & ~bv; y = 16'hFFFF;  l = av & ~bv;   end
         4'h8: begin x = av;       y = av & bv;   l = ~av | bv;   end
         4'h9: begin x = av;       y = bv;        l = ~(av ^ bv); end
         4'hA: begin x = av | ~bv; y = av & bv;   l = bv;         end
         4'hB: begin x = av & bv;  y = 16'hFFFF;  l = av & bv;    end
         4'hC: begin x = av;       y = av;        l = 16'hFFFF;   end
         4'hD: begin x = av | bv;  y = av;        l = av | ~bv;   end
         4'hE: begin x = av | ~bv; y = av;        l = av | bv;    end
         default: begin x = av;    y = 16'hFFFF;  l = av;         end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {16'h0000, cv};
      v = hv(av, bv, sv, mv, cv, mv ? l : sum[15:0], mv ? 1'b0 : sum[16], av == bv, 1'b0);
      v.ez = (v.ef == 16'h0000);
      return v;
   endfunction

   // Present a bundle at a negedge and push its expectation when it is taken.
   task automatic send(input vec_t v);
      a = v.a; b = v.b; s = v.s; m = v.m; c_in = v.c; in_valid = 1'b1;
      chk("in_ready_before_accept", in_ready, 1'b1);
      @(posedge clk);
      exp_q.push_back(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count edges from acceptance until out_valid, with a bounded wait.
   task automatic wait_result();
      int lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, LAT);
   endtask

   task automatic check_result(input string tag);
      vec_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         $display("op a=%h b=%h s=%b m=%b c=%b -> f=%h c_out=%b eq=%b zero=%b",
                  e.a, e.b, e.s, e.m, e.c, f, c_out, a_eq_b, zero);
         chk({tag, "_f"}, f, e.ef);
         chk({tag, "_c_out"}, c_out, e.eco);
         chk({tag, "_a_eq_b"}, a_eq_b, e.eeq);
         chk({tag, "_zero"}, zero, e.ez);
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_hs", out_valid, 1'b0);
      chk("in_ready_after_hs", in_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v, v2;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;

      tbl[0]  = hv(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      tbl[1]  = hv(16'h0000, 16'h5A5A, 4'b1111, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tbl[2]  = hv(16'h0001, 16'h5A5A, 4'b1111, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      tbl[3]  = hv(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
      tbl[4]  = hv(16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tbl[5]  = hv(16'h1234, 16'h1234, 4'b0011, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      tbl[6]  = hv(16'h0000, 16'h0000, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      tbl[7]  = hv(16'h8000, 16'h0000, 4'b1100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      tbl[8]  = hv(16'hFFFF, 16'h0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      tbl[9]  = hv(16'h0001, 16'h0002, 4'b0011, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      tbl[10] = hv(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);
      tbl[11] = hv(16'h00F0, 16'h0030, 4'b0100, 1'b0, 1'b0, 16'h01B0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_f", f, 16'h0000);
      chk("rst_c_out", c_out, 1'b0);
      chk("rst_a_eq_b", a_eq_b, 1'b0);
      chk("rst_zero", zero, 1'b0);

      for (int i = 0; i < 12; i++) begin
         send(tbl[i]);
         wait_result();
         check_result("vec");
         release_out();
      end

      for (int i = 0; i < 16; i++) begin
         v = model(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         send(v);
         wait_result();
         check_result("rnd");
         release_out();
      end

      // Backpressure: the result must hold while a new bundle waits.
      v  = hv(16'h0F0F, 16'h00F1, 4'b1001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      v2 = hv(16'h0002, 16'h0003, 4'b1001, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
      send(v);
      wait_result();
      a = v2.a; b = v2.b; s = v2.s; m = v2.m; c_in = v2.c; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_f", f, v.ef);
         chk("bp_c_out", c_out, v.eco);
         chk("bp_zero", zero, v.ez);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      check_result("bp");
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_in_ready_after", in_ready, 1'b1);
      chk("bp_out_valid_after", out_valid, 1'b0);
      @(posedge clk);
      exp_q.push_back(v2);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_new_taken", in_ready, 1'b0);
      wait_result();
      check_result("bp_new");
      release_out();

      // Reset while slice 2 is being evaluated; the partial result is dropped.
      v = hv(16'h7777, 16'h7777, 4'b1001, 1'b0, 1'b0, 16'hEEEE, 1'b0, 1'b1, 1'b0);
      send(v);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      void'(exp_q.pop_front());
      chk("mid_rst_f", f, 16'h0000);
      chk("mid_rst_c_out", c_out, 1'b0);
      chk("mid_rst_a_eq_b", a_eq_b, 1'b0);
      chk("mid_rst_zero", zero, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      send(hv(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0));
      wait_result();
      check_result("post_rst");
      release_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ula_74181_seq.md
# ula_74181_seq

Parametrised, slice-serial successor of the 4-bit 74181 ALU. It evaluates the full 32-function 74181 set (16 logic, 16 arithmetic) on WIDTH-bit operands by cascading 4-bit slices, one slice per clock, with the carry held in a register between slices. Operands enter and results leave through valid/ready handshakes, so the block sits directly on the datapath bus between the operand register file and the result writeback stage.

## Interface
- WIDTH, default 16: operand and result width; must be a multiple of 4 and at least 4. NSLICE = WIDTH/4 is derived.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- a, b  in  WIDTH  operands.
- s  in  4  function select.
- m  in  1  mode: 1 = logic, 0 = arithmetic.
- c_in  in  1  carry into slice 0, active-high (1 adds one).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  result.
- c_out  out  1  carry out of the top slice; forced to 0 when m=1.
- a_eq_b  out  1  1 when the latched a equals the latched b.
- zero  out  1  1 when f is all zeros.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid=1, the block latches a, b, s, m and c_in, loads c_in into the carry register, clears the slice index, and moves to BUSY. in_ready=0 in every other state. Inputs presented outside IDLE are ignored.
- BUSY: each cycle the block evaluates slice k (bits 4k+3..4k) and writes it into the f register.
  - The carry register takes the slice carry-out.
  - k increments; after slice NSLICE-1 the block moves to DONE.
- DONE: out_valid=1. f, c_out, a_eq_b and zero stay stable until out_ready=1, then the block returns to IDLE.
- Logic functions (m=1), bitwise, no carry:
  - 0000 ~a; 0001 ~(a|b); 0010 ~a&b; 0011 0.
  - 0100 ~(a&b); 0101 ~b; 0110 a^b; 0111 a&~b.
  - 1000 ~a|b; 1001 ~(a^b); 1010 b; 1011 a&b.
  - 1100 all-ones; 1101 a|~b; 1110 a|b; 1111 a.
- Arithmetic functions (m=0): result = X + Y + c_in mod 2^WIDTH, and c_out is bit WIDTH of the sum. "ones" means all-ones. Per s:
  - 0000 a+0; 0001 (a|b)+0; 0010 (a|~b)+0; 0011 0+ones.
  - 0100 a+(a&~b); 0101 (a|b)+(a&~b); 0110 a+~b; 0111 (a&~b)+ones.
  - 1000 a+(a&b); 1001 a+b; 1010 (a|~b)+(a&b); 1011 (a&b)+ones.
  - 1100 a+a; 1101 (a|b)+a; 1110 (a|~b)+a; 1111 a+ones.
- X and Y are bitwise functions of a and b, so the per-slice 4-bit add plus the registered carry reproduces the full-width sum exactly.
- a_eq_b is computed from the latched operands and is independent of s and m.
- zero is computed from the final f.

## Timing
- Reset (rst_n=0 at an edge) forces state=IDLE, and sets f, c_out, a_eq_b, zero, out_valid, the carry register and the slice index to 0.
  - Reset applies in any state, including mid-BUSY; a partial result is discarded.
- in_ready is 1 in the first cycle after reset is released.
- Latency: acceptance at edge E gives out_valid=1 after edge E+NSLICE (4 cycles at WIDTH=16).
- Throughput: one operation per NSLICE+2 cycles with out_ready held at 1.
- f is partially updated during BUSY. Its value is defined only while out_valid=1.
- The out handshake completes at an edge where out_valid=1 and out_ready=1. After that edge, out_valid=0 and in_ready=1.

## Configuration
- Macro: ULA_74181_PARALLEL_EN.
- Defined: all NSLICE slices are evaluated in a single cycle (ripple carry across slices). BUSY lasts one cycle, and latency is 1 for every WIDTH.
- Undefined: slice-serial operation as described above. Latency is NSLICE.
- Results, flags, handshake and reset behaviour are identical in both builds. Only latency differs.

## Test plan
- WIDTH=16, m=0, s=1001, a=0x00FF, b=0x0001, c_in=0 -> f=0x0100, c_out=0, zero=0; out_valid exactly 4 edges after acceptance (1 edge with ULA_74181_PARALLEL_EN).
- m=0, s=1111, c_in=0: with a=0x0000 -> f=0xFFFF, c_out=0; then with a=0x0001 -> f=0x0000, c_out=1, zero=1.
- m=0, s=0110, a=b=0x1234, c_in=1 -> f=0x0000, c_out=1, a_eq_b=1, zero=1.
- m=1, s=0110, a=0xAAAA, b=0x5555, c_in=1 -> f=0xFFFF, c_out=0, a_eq_b=0.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands applied -> f and flags unchanged, in_ready=0, new bundle not taken. Raise out_ready -> next cycle in_ready=1 and the new bundle is accepted.
- Reset mid-operation: rst_n=0 for one edge during BUSY slice 2 -> all outputs 0 and in_ready=1 after release. The following op (s=1001, a=0x0F0F, b=0x0101) gives f=0x1010.
